// File: rtl/io_controller.sv
// I/O front end: input FIFO (fall-through head to decode mux) plus a one-entry output register.
// Push/pop/write take effect at the edge; ready/valid come from registered state only.
module io_controller #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       io_cntrl_en,
  input  logic                       ext_in_valid,
  input  logic [DATA_W-1:0]          ext_in_data,
  output logic                       ext_in_ready,
  input  logic                       io_rd,
  output logic [DATA_W-1:0]          io_in,
  output logic                       io_in_valid,
  input  logic                       io_wr,
  input  logic [DATA_W-1:0]          io_wr_data,
  output logic                       ext_out_valid,
  output logic [DATA_W-1:0]          ext_out_data,
  input  logic                       ext_out_ready,
  output logic [$clog2(DEPTH):0]     in_count,
  output logic                       underflow,
  output logic                       overrun,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_underflow;
  logic              r_overrun;

  logic w_push;
  logic w_pop;
  logic w_pop_empty;
  logic w_wr;
  logic w_drop;

  // Ready/valid derive from the registered count, so no input-to-ready path exists.
  assign ext_in_ready = (r_count < CW'(DEPTH));
  assign io_in_valid  = (r_count != '0);
  assign io_in        = io_in_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push      = ext_in_valid & ext_in_ready;
  assign w_pop       = io_cntrl_en & io_rd & io_in_valid;
  assign w_pop_empty = io_cntrl_en & io_rd & ~io_in_valid;
  assign w_wr        = io_cntrl_en & io_wr;
  assign w_drop      = w_wr & r_out_vld & ~ext_out_ready;

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_mem[r_wr_ptr] <= ext_in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A full register accepts a new word only when the old one drains on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else if (!r_out_vld) begin
      if (w_wr) begin
        r_out_vld <= 1'b1;
        r_out_dat <= io_wr_data;
      end
    end else if (ext_out_ready) begin
      if (w_wr)
        r_out_dat <= io_wr_data;
      else
        r_out_vld <= 1'b0;
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_pop_empty)
        r_underflow <= 1'b1;
      else if (err_clr)
        r_underflow <= 1'b0;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (err_clr)
        r_overrun <= 1'b0;
    end
  end

  assign ext_out_valid = r_out_vld;
  assign ext_out_data  = r_out_dat;
  assign in_count      = r_count;
  assign underflow     = r_underflow;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: vector table for single-cycle behaviour, queue scoreboard for FIFO ordering.
module tb_io_controller;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              io_cntrl_en;
  logic              ext_in_valid;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_ready;
  logic              io_rd;
  logic [DATA_W-1:0] io_in;
  logic              io_in_valid;
  logic              io_wr;
  logic [DATA_W-1:0] io_wr_data;
  logic              ext_out_valid;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_ready;
  logic [2:0]        in_count;
  logic              underflow;
  logic              overrun;
  logic              err_clr;

  io_controller #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_cntrl_en(io_cntrl_en),
    .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
    .io_rd(io_rd), .io_in(io_in), .io_in_valid(io_in_valid),
    .io_wr(io_wr), .io_wr_data(io_wr_data),
    .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready),
    .in_count(in_count), .underflow(underflow), .overrun(overrun), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic        r, en, iv;
    logic [31:0] id;
    logic        rd, wr;
    logic [31:0] wd;
    logic        ordy, clr;
    logic        e_iv;
    logic [31:0] e_io;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [31:0] e_od;
    logic        cd, e_u, e_o;
  } vec_t;

  vec_t vt [24];

  // Scoreboarded cycle: the queue predicts ready, count and head word.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic rd);
    logic acc;
    logic pop;
    io_cntrl_en = 1'b1; ext_in_valid = iv; ext_in_data = d; io_rd = rd;
    io_wr = 1'b0; err_clr = 1'b0;
    acc = iv && (sb_q.size() < DEPTH);
    pop = rd && (sb_q.size() > 0);
    chk("in_ready_pre", {31'd0, ext_in_ready}, (sb_q.size() < DEPTH) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    if (pop) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(d);
    chk("sb_count", {29'd0, in_count}, sb_q.size());
    chk("sb_in_valid", {31'd0, io_in_valid}, (sb_q.size() > 0) ? 32'd1 : 32'd0);
    chk("sb_io_in", io_in, (sb_q.size() > 0) ? sb_q[0] : 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 10) begin
      cyc(1'b0, 32'd0, 1'b1);
      n++;
    end
    chk("drain_bound", sb_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; io_cntrl_en = 1'b0; ext_in_valid = 1'b0; ext_in_data = '0;
    io_rd = 1'b0; io_wr = 1'b0; io_wr_data = '0; ext_out_ready = 1'b0; err_clr = 1'b0;

    //        r en iv id           rd wr wd           ordy clr | eiv eio    erdy cnt eov eod          cd eu eo
    vt[0]  = '{1, 0, 0, 0,          0, 0, 0,           0, 0,    0, 0,      1, 0, 0, 0,            1, 0, 0};
    vt[1]  = '{0, 0, 1, 'h11,       0, 0, 0,           0, 0,    1, 'h11,   1, 1, 0, 0,            0, 0, 0};
    vt[2]  = '{0, 0, 1, 'h22,       0, 0, 0,           0, 0,    1, 'h11,   1, 2, 0, 0,            0, 0, 0};
    vt[3]  = '{0, 0, 1, 'h33,       0, 0, 0,           0, 0,    1, 'h11,   1, 3, 0, 0,            0, 0, 0};
    vt[4]  = '{0, 0, 1, 'h44,       0, 0, 0,           0, 0,    1, 'h11,   0, 4, 0, 0,            0, 0, 0};
    vt[5]  = '{0, 0, 1, 'h55,       0, 0, 0,           0, 0,    1, 'h11,   0, 4, 0, 0,            0, 0, 0};
    vt[6]  = '{0, 1, 0, 0,          1, 0, 0,           0, 0,    1, 'h22,   1, 3, 0, 0,            0, 0, 0};
    vt[7]  = '{0, 1, 0, 0,          1, 0, 0,           0, 0,    1, 'h33,   1, 2, 0, 0,            0, 0, 0};
    vt[8]  = '{0, 1, 0, 0,          1, 0, 0,           0, 0,    1, 'h44,   1, 1, 0, 0,            0, 0, 0};
    vt[9]  = '{0, 1, 0, 0,          1, 0, 0,           0, 0,    0, 0,      1, 0, 0, 0,            0, 0, 0};
    vt[10] = '{0, 1, 0, 0,          1, 0, 0,           0, 0,    0, 0,      1, 0, 0, 0,            0, 1, 0};
    vt[11] = '{0, 0, 0, 0,          0, 0, 0,           0, 1,    0, 0,      1, 0, 0, 0,            0, 0, 0};
    vt[12] = '{0, 0, 0, 0,          1, 0, 0,           0, 0,    0, 0,      1, 0, 0, 0,            0, 0, 0};
    vt[13] = '{0, 1, 0, 0,          1, 0, 0,           0, 1,    0, 0,      1, 0, 0, 0,            0, 1, 0};
    vt[14] = '{0, 0, 0, 0,          0, 0, 0,           0, 1,    0, 0,      1, 0, 0, 0,            0, 0, 0};
    vt[15] = '{0, 1, 0, 0,          0, 1, 'hDEADBEEF,  0, 0,    0, 0,      1, 0, 1, 'hDEADBEEF,   1, 0, 0};
    vt[16] = '{0, 1, 0, 0,          0, 1, 'h12345678,  0, 0,    0, 0,      1, 0, 1, 'hDEADBEEF,   1, 0, 1};
    vt[17] = '{0, 1, 0, 0,          0, 1, 'hCAFEF00D,  1, 0,    0, 0,      1, 0, 1, 'hCAFEF00D,   1, 0, 1};
    vt[18] = '{0, 0, 0, 0,          0, 0, 0,           1, 0,    0, 0,      1, 0, 0, 0,            0, 0, 1};
    vt[19] = '{0, 0, 0, 0,          0, 1, 'h99,        0, 0,    0, 0,      1, 0, 0, 0,            0, 0, 1};
    vt[20] = '{0, 0, 0, 0,          0, 0, 0,           0, 1,    0, 0,      1, 0, 0, 0,            0, 0, 0};
    vt[21] = '{0, 1, 0, 0,          0, 1, 'h77,        1, 0,    0, 0,      1, 0, 1, 'h77,         1, 0, 0};
    vt[22] = '{0, 0, 0, 0,          0, 1, 'h88,        0, 0,    0, 0,      1, 0, 1, 'h77,         1, 0, 0};
    vt[23] = '{0, 0, 0, 0,          0, 0, 0,           1, 0,    0, 0,      1, 0, 0, 0,            0, 0, 0};

    for (int i = 0; i < 24; i++) begin
      rst = vt[i].r; io_cntrl_en = vt[i].en; ext_in_valid = vt[i].iv; ext_in_data = vt[i].id;
      io_rd = vt[i].rd; io_wr = vt[i].wr; io_wr_data = vt[i].wd;
      ext_out_ready = vt[i].ordy; err_clr = vt[i].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_in_valid", i), {31'd0, io_in_valid}, {31'd0, vt[i].e_iv});
      chk($sformatf("v%0d_io_in", i), io_in, vt[i].e_io);
      chk($sformatf("v%0d_in_ready", i), {31'd0, ext_in_ready}, {31'd0, vt[i].e_rdy});
      chk($sformatf("v%0d_in_count", i), {29'd0, in_count}, {29'd0, vt[i].e_cnt});
      chk($sformatf("v%0d_out_valid", i), {31'd0, ext_out_valid}, {31'd0, vt[i].e_ov});
      if (vt[i].cd) chk($sformatf("v%0d_out_data", i), ext_out_data, vt[i].e_od);
      chk($sformatf("v%0d_underflow", i), {31'd0, underflow}, {31'd0, vt[i].e_u});
      chk($sformatf("v%0d_overrun", i), {31'd0, overrun}, {31'd0, vt[i].e_o});
    end
    rst = 1'b0; ext_out_ready = 1'b0; io_wr = 1'b0; err_clr = 1'b0;

    // Six pushes with a pop every cycle from the second: order must survive the wrap.
    for (int k = 0; k < 6; k++)
      cyc(1'b1, 32'h100 + k, k >= 1);
    drain();
    chk("wrap_empty_io_in", io_in, 32'd0);

    // Full FIFO: pop with valid held; ready returns next cycle and the word is taken.
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 32'h200 + k, 1'b0);
    cyc(1'b1, 32'hBB, 1'b1);
    chk("full_pop_count", {29'd0, in_count}, 32'd3);
    cyc(1'b1, 32'hBB, 1'b0);
    chk("full_then_push_count", {29'd0, in_count}, 32'd4);
    drain();

    // Reset with three queued words and a full output register.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 32'h300 + k, 1'b0);
    io_wr = 1'b1; io_wr_data = 32'h5A5A5A5A; ext_in_valid = 1'b0; ext_out_ready = 1'b0;
    @(posedge clk); #1;
    io_wr = 1'b0;
    chk("pre_rst_out_valid", {31'd0, ext_out_valid}, 32'd1);
    rst = 1'b1; ext_in_valid = 1'b1; ext_in_data = 32'hEE; io_wr = 1'b1; io_rd = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; io_wr = 1'b0; io_rd = 1'b0; ext_in_valid = 1'b0;
    sb_q.delete();
    chk("rst_in_valid", {31'd0, io_in_valid}, 32'd0);
    chk("rst_io_in", io_in, 32'd0);
    chk("rst_in_ready", {31'd0, ext_in_ready}, 32'd1);
    chk("rst_count", {29'd0, in_count}, 32'd0);
    chk("rst_out_valid", {31'd0, ext_out_valid}, 32'd0);
    chk("rst_out_data", ext_out_data, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    cyc(1'b1, 32'hA5, 1'b0);
    chk("post_rst_io_in", io_in, 32'hA5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
